// File: rtl/differentiator_pkg.sv
// differentiator_pkg: shared FSM states, default widths and term record for the differentiator datapath
package differentiator_pkg;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  localparam int COEF_W = 8;
  localparam int EXP_W  = 8;
  localparam int CNT_W  = 8;
  typedef struct packed {
    logic signed [COEF_W-1:0] coef;
    logic [EXP_W-1:0]         exp;
    logic                     last;
  } term_t;
endpackage

// File: rtl/deriv_term_alu.sv
// deriv_term_alu: power-rule arithmetic for one term (coef*exp, exp-1, constant detect)
module deriv_term_alu #(
  parameter int COEF_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic signed [COEF_W-1:0]       coef,
  input  logic [EXP_W-1:0]               exp,
  output logic signed [COEF_W+EXP_W-1:0] prod,
  output logic [EXP_W-1:0]               exp_m1,
  output logic                           is_const
);
  // Exponent is zero-extended so it multiplies as a non-negative signed value
  assign prod     = $signed({{EXP_W{coef[COEF_W-1]}}, coef}) * $signed({{COEF_W{1'b0}}, exp});
  assign exp_m1   = exp - 1'b1;
  assign is_const = exp == '0;
endmodule

// File: rtl/poly_deriv_sequencer.sv
// poly_deriv_sequencer: streams polynomial terms through the power rule with valid/ready on both sides
module poly_deriv_sequencer #(
  parameter int COEF_W = differentiator_pkg::COEF_W,
  parameter int EXP_W  = differentiator_pkg::EXP_W,
  parameter int CNT_W  = differentiator_pkg::CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [COEF_W-1:0]       in_coef,
  input  logic [EXP_W-1:0]               in_exp,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [COEF_W+EXP_W-1:0] out_coef,
  output logic [EXP_W-1:0]               out_exp,
  output logic                           out_last,
  output logic [CNT_W-1:0]               term_cnt,
  output logic                           poly_done,
  output logic                           busy
);
  import differentiator_pkg::*;
  state_t state_q, state_d;
  logic signed [COEF_W-1:0] coef_q, coef_d;
  logic [EXP_W-1:0] exp_q, exp_d, out_exp_q, out_exp_d, exp_m1;
  logic signed [COEF_W+EXP_W-1:0] out_coef_q, out_coef_d, prod;
  logic last_q, last_d, out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic poly_done_q, poly_done_d, is_const, drop, out_fire;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  deriv_term_alu #(.COEF_W(COEF_W), .EXP_W(EXP_W)) u_alu (
    .coef(coef_q), .exp(exp_q), .prod(prod), .exp_m1(exp_m1), .is_const(is_const)
  );
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_exp   = out_exp_q;
  assign out_last  = out_last_q;
  assign term_cnt  = term_cnt_q;
  assign poly_done = poly_done_q;
  assign out_fire  = out_valid_q && out_ready;
  // A constant term only produces a beat when it closes the polynomial
  assign drop      = is_const && !last_q;
  always_comb begin
    state_d     = state_q;
    coef_d      = coef_q;
    exp_d       = exp_q;
    last_d      = last_q;
    out_coef_d  = out_coef_q;
    out_exp_d   = out_exp_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    poly_done_d = out_fire && out_last_q;
    term_cnt_d  = poly_done_q ? '0 :
                  (out_fire && out_coef_q != '0 && term_cnt_q != '1) ? term_cnt_q + 1'b1 : term_cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        coef_d  = in_coef;
        exp_d   = in_exp;
        last_d  = in_last;
        state_d = CALC;
      end
      CALC: begin
        out_coef_d  = is_const ? '0 : prod;
        out_exp_d   = is_const ? '0 : exp_m1;
        out_last_d  = last_q;
        out_valid_d = !drop;
        state_d     = drop ? IDLE : HOLD;
      end
      HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      coef_q      <= '0;
      exp_q       <= '0;
      last_q      <= 1'b0;
      out_coef_q  <= '0;
      out_exp_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      poly_done_q <= 1'b0;
      term_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      coef_q      <= coef_d;
      exp_q       <= exp_d;
      last_q      <= last_d;
      out_coef_q  <= out_coef_d;
      out_exp_q   <= out_exp_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      poly_done_q <= poly_done_d;
      term_cnt_q  <= term_cnt_d;
    end
  end
endmodule

// File: tb/tb_poly_deriv_sequencer.sv
// tb_poly_deriv_sequencer: table-driven directed vectors plus backpressure and mid-operation reset sequences
module tb_poly_deriv_sequencer;
  import differentiator_pkg::*;
  typedef struct {
    term_t              t;
    logic signed [15:0] ecoef;
    logic [7:0]         eexp;
    logic               elast;
    logic               drop;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic signed [7:0] in_coef = '0;
  logic [7:0] in_exp = '0;
  logic out_valid, out_ready = 1'b1, out_last, poly_done, busy;
  logic signed [15:0] out_coef;
  logic [7:0] out_exp, term_cnt;
  int n_vec = 0, n_err = 0, cnt = 0;
  vec_t v[10];
  always #5 clk = ~clk;
  poly_deriv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .in_exp(in_exp), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_exp(out_exp), .out_last(out_last), .term_cnt(term_cnt),
    .poly_done(poly_done), .busy(busy)
  );
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  function automatic vec_t mk(input int c, input int e, input int l, input int ec, input int ee,
                              input int el, input int d);
    vec_t r;
    r.t.coef = 8'(c);
    r.t.exp  = 8'(e);
    r.t.last = l[0];
    r.ecoef  = 16'(ec);
    r.eexp   = 8'(ee);
    r.elast  = el[0];
    r.drop   = d[0];
    return r;
  endfunction
  task automatic drive(input int c, input int e, input logic l);
    in_valid = 1'b1;
    in_coef  = 8'(c);
    in_exp   = 8'(e);
    in_last  = l;
  endtask
  task automatic send(input vec_t x);
    @(negedge clk);
    drive(x.t.coef, x.t.exp, x.t.last);
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("calc_out_valid", out_valid, 0);
    chk("calc_in_ready", in_ready, 0);
    chk("calc_busy", busy, 1);
    @(negedge clk);
    if (x.drop) begin
      chk("drop_no_beat", out_valid, 0);
      chk("drop_in_ready", in_ready, 1);
    end else begin
      chk("hold_out_valid", out_valid, 1);
      chk("out_coef", out_coef, x.ecoef);
      chk("out_exp", out_exp, x.eexp);
      chk("out_last", out_last, x.elast);
      if (x.ecoef != 0 && cnt < 255) cnt++;
      @(negedge clk);
      chk("after_fire_valid", out_valid, 0);
      chk("poly_done", poly_done, x.t.last);
      chk("term_cnt", term_cnt, cnt);
      if (x.t.last) begin
        cnt = 0;
        @(negedge clk);
        chk("poly_done_single_pulse", poly_done, 0);
        chk("term_cnt_cleared", term_cnt, 0);
      end
    end
  endtask
  initial begin
    v[0] = mk(3, 2, 0, 6, 1, 0, 0);
    v[1] = mk(5, 1, 0, 5, 0, 0, 0);
    v[2] = mk(7, 0, 1, 0, 0, 1, 0);
    v[3] = mk(-128, 255, 1, -32640, 254, 1, 0);
    v[4] = mk(9, 0, 0, 0, 0, 0, 1);
    v[5] = mk(2, 4, 1, 8, 3, 1, 0);
    v[6] = mk(0, 5, 1, 0, 4, 1, 0);
    v[7] = mk(-3, 3, 0, -9, 2, 0, 0);
    v[8] = mk(-1, 0, 0, 0, 0, 0, 1);
    v[9] = mk(127, 255, 1, 32385, 254, 1, 0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_term_cnt", term_cnt, 0);
    chk("rst_poly_done", poly_done, 0);
    chk("rst_out_coef", out_coef, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    for (int i = 0; i < 10; i++) send(v[i]);
    // Backpressure: (4,3) held five cycles, then released
    @(negedge clk);
    out_ready = 1'b0;
    drive(4, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_coef", out_coef, 12);
      chk("bp_exp", out_exp, 2);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", out_valid, 0);
    chk("bp_cnt", term_cnt, 1);
    @(negedge clk);
    chk("bp_single_beat", out_valid, 0);
    cnt = 1;
    send(mk(1, 0, 1, 0, 0, 1, 0));
    // Reset while a (6,1) beat is pending after one counted term
    send(mk(2, 2, 0, 4, 1, 0, 0));
    @(negedge clk);
    out_ready = 1'b0;
    drive(3, 2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_coef", out_coef, 6);
    chk("pre_rst_cnt", term_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", term_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_no_beat", out_valid, 0);
      chk("post_rst_cnt", term_cnt, 0);
    end
    send(mk(-2, 1, 1, -2, 0, 1, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
